// File: rtl/rx_lp_pkg.sv
// Shared constants, FSM state type, coefficient tables and output rounding
// for the receive-path low-pass FIR sequencer.
package rx_lp_pkg;

    localparam int TAPS   = 128;
    localparam int DATA_W = 16;
    localparam int ACC_W  = 40;
    localparam int FRAC   = 15;
    localparam int AW     = $clog2(TAPS);

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        IDLE  = 2'd1,
        MAC   = 2'd2,
        DONE  = 2'd3
    } fir_state_e;

    // Element k of the table is the coefficient applied to tap k.
    typedef logic [TAPS-1:0][DATA_W-1:0] coef_arr_t;

    // Bartlett (triangular) low-pass in Q1.15: 8 * min(k+1, TAPS-k), peak 512.
    function automatic coef_arr_t build_lp_coef();
        coef_arr_t c;
        int        m;
        c = '0;
        for (int k = 0; k < TAPS; k++) begin
            m    = ((k + 1) < (TAPS - k)) ? (k + 1) : (TAPS - k);
            c[k] = DATA_W'(m * 8);
        end
        return c;
    endfunction

    localparam coef_arr_t LP_COEF   = build_lp_coef();
    localparam coef_arr_t TEST_COEF = {TAPS{16'h0400}};

    localparam logic signed [ACC_W-1:0] RND_HALF = 40'sd16384;
    localparam logic signed [ACC_W-1:0] SAT_MAX  = 40'sd32767;
    localparam logic signed [ACC_W-1:0] SAT_MIN  = -40'sd32768;

    // Round half up, shift out the fractional bits, clamp to the sample range.
    function automatic logic signed [DATA_W-1:0] round_sat(input logic signed [ACC_W-1:0] acc);
        logic signed [ACC_W-1:0] r;
        r = (acc + RND_HALF) >>> FRAC;
        if (r > SAT_MAX) begin
            return 16'sh7fff;
        end else if (r < SAT_MIN) begin
            return 16'sh8000;
        end else begin
            return r[DATA_W-1:0];
        end
    endfunction

endpackage

// File: rtl/rx_BRAM_16_128_low_pass.sv
// 16x128 simple dual-port block RAM: port A writes, port B reads with one
// cycle of latency. Only the read data register is reset.
module rx_BRAM_16_128_low_pass
    import rx_lp_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    input  logic              wea,
    input  logic [AW-1:0]     addra,
    input  logic [DATA_W-1:0] dina,
    input  logic              enb,
    input  logic [AW-1:0]     addrb,
    output logic [DATA_W-1:0] doutb
);

    logic [DATA_W-1:0] mem_q [0:TAPS-1];

    // Write port A.
    always_ff @(posedge clk) begin
        if (ena && wea) begin
            mem_q[addra] <= dina;
        end
    end

    // Registered read port B.
    always_ff @(posedge clk) begin
        if (rst) begin
            doutb <= '0;
        end else if (enb) begin
            doutb <= mem_q[addrb];
        end
    end

endmodule

// File: rtl/rx_low_pass_fir_ctrl.sv
// Receive low-pass FIR sequencer: clears the history buffer, writes each
// accepted sample, then walks all taps through a 3-stage MAC pipeline
// (RAM read / product / accumulate) and emits one rounded, saturated sample.
module rx_low_pass_fir_ctrl
    import rx_lp_pkg::*;
#(
    parameter int COEF_SEL = 0
) (
    input  logic                     clk,
    input  logic                     rrx_rst,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] in_sample,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic signed [DATA_W-1:0] out_sample,
    output logic                     busy
);

    localparam int               CNT_W    = AW + 1;
    localparam logic [CNT_W-1:0] CLR_LAST = CNT_W'(TAPS - 1);
    localparam logic [CNT_W-1:0] MAC_LAST = CNT_W'(TAPS);
    localparam coef_arr_t        COEF_TBL = (COEF_SEL == 1) ? TEST_COEF : LP_COEF;

    fir_state_e                state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [AW-1:0]             wr_ptr_q, wr_ptr_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic                      rd_vld_q, prod_vld_q;
    logic signed [DATA_W-1:0]  coef_q;
    logic signed [2*DATA_W-1:0] prod_q;
    logic                      out_valid_q;
    logic signed [DATA_W-1:0]  out_sample_q;

    logic                      ram_ena_s, ram_wea_s, ram_enb_s, issue_s;
    logic [AW-1:0]             ram_addra_s, ram_addrb_s;
    logic [DATA_W-1:0]         ram_dina_s, ram_doutb_s;

    rx_BRAM_16_128_low_pass u_hist (
        .clk   (clk),
        .rst   (rrx_rst),
        .ena   (ram_ena_s),
        .wea   (ram_wea_s),
        .addra (ram_addra_s),
        .dina  (ram_dina_s),
        .enb   (ram_enb_s),
        .addrb (ram_addrb_s),
        .doutb (ram_doutb_s)
    );

    // FSM state, shared clear/tap counter and history write pointer.
    always_ff @(posedge clk) begin
        if (rrx_rst) begin
            state_q  <= CLEAR;
            cnt_q    <= '0;
            wr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

    // Next-state logic: CLEAR runs TAPS writes, MAC runs TAPS issues plus one drain cycle.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        wr_ptr_d = wr_ptr_q;
        case (state_q)
            CLEAR: begin
                if (cnt_q == CLR_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            IDLE: begin
                if (in_valid) begin
                    state_d = MAC;
                    cnt_d   = '0;
                end else begin
                    cnt_d = '0;
                end
            end
            MAC: begin
                if (cnt_q == MAC_LAST) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d  = IDLE;
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            default: begin
                state_d = CLEAR;
                cnt_d   = '0;
            end
        endcase
    end

    // Buffer port controls and handshake decoded from the current state.
    always_comb begin
        in_ready    = 1'b0;
        ram_ena_s   = 1'b0;
        ram_wea_s   = 1'b0;
        ram_addra_s = wr_ptr_q;
        ram_dina_s  = '0;
        ram_enb_s   = 1'b0;
        ram_addrb_s = wr_ptr_q - cnt_q[AW-1:0];
        issue_s     = 1'b0;
        case (state_q)
            CLEAR: begin
                ram_ena_s   = 1'b1;
                ram_wea_s   = 1'b1;
                ram_addra_s = cnt_q[AW-1:0];
            end
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    ram_ena_s  = 1'b1;
                    ram_wea_s  = 1'b1;
                    ram_dina_s = in_sample;
                end else begin
                    ram_ena_s = 1'b0;
                end
            end
            MAC: begin
                if (!cnt_q[AW]) begin
                    ram_enb_s = 1'b1;
                    issue_s   = 1'b1;
                end else begin
                    ram_enb_s = 1'b0;
                end
            end
            DONE: begin
                in_ready = 1'b0;
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

    // Accumulator next value: zeroed at accept, summed while products are valid.
    always_comb begin
        acc_d = acc_q;
        if ((state_q == IDLE) && in_valid) begin
            acc_d = '0;
        end else if (prod_vld_q) begin
            acc_d = acc_q + {{(ACC_W-2*DATA_W){prod_q[2*DATA_W-1]}}, prod_q};
        end else begin
            acc_d = acc_q;
        end
    end

    // MAC pipeline registers and registered outputs; DONE folds in the last product.
    always_ff @(posedge clk) begin
        if (rrx_rst) begin
            rd_vld_q     <= 1'b0;
            prod_vld_q   <= 1'b0;
            coef_q       <= '0;
            prod_q       <= '0;
            acc_q        <= '0;
            out_valid_q  <= 1'b0;
            out_sample_q <= '0;
        end else begin
            rd_vld_q   <= issue_s;
            prod_vld_q <= rd_vld_q;
            if (issue_s) begin
                coef_q <= COEF_TBL[cnt_q[AW-1:0]];
            end
            if (rd_vld_q) begin
                prod_q <= $signed(ram_doutb_s) * coef_q;
            end
            acc_q       <= acc_d;
            out_valid_q <= (state_q == DONE);
            if (state_q == DONE) begin
                out_sample_q <= round_sat(acc_d);
            end
        end
    end

    assign out_valid  = out_valid_q;
    assign out_sample = out_sample_q;
    assign busy       = !in_ready;

endmodule

// File: tb/tb_rx_low_pass_fir_ctrl.sv
// Bench for rx_low_pass_fir_ctrl: two instances (test and low-pass
// coefficients) share one stimulus stream; a reference model pushes the
// expected outputs and their due cycle into a queue at every accept.
module tb_rx_low_pass_fir_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rrx_rst;
    logic               in_valid;
    logic signed [15:0] in_sample;
    logic               in_ready_t, out_valid_t, busy_t;
    logic               in_ready_l, out_valid_l, busy_l;
    logic signed [15:0] out_sample_t, out_sample_l;

    rx_low_pass_fir_ctrl #(.COEF_SEL(1)) dut_t (
        .clk(clk), .rrx_rst(rrx_rst), .in_valid(in_valid), .in_sample(in_sample),
        .in_ready(in_ready_t), .out_valid(out_valid_t), .out_sample(out_sample_t), .busy(busy_t)
    );

    rx_low_pass_fir_ctrl #(.COEF_SEL(0)) dut_l (
        .clk(clk), .rrx_rst(rrx_rst), .in_valid(in_valid), .in_sample(in_sample),
        .in_ready(in_ready_l), .out_valid(out_valid_l), .out_sample(out_sample_l), .busy(busy_l)
    );

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic signed [15:0] sample;
        int                 count;
        logic signed [15:0] exp_last;
    } seg_t;

    typedef struct {
        logic signed [15:0] e_t;
        logic signed [15:0] e_l;
        longint             due;
        bit                 has_tbl;
        logic signed [15:0] tbl_v;
    } sb_t;

    sb_t                sbq[$];
    logic signed [15:0] hist [128];
    int                 ptr;
    int                 coef_l [128];
    int                 total = 0;
    int                 bad   = 0;
    bit                 contig;
    longint             last_acc;

    task automatic chk(input string name, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic signed [15:0] rsat(input longint acc);
        longint r;
        r = (acc + 64'sd16384) >>> 15;
        if (r > 64'sd32767) return 16'sh7fff;
        if (r < -64'sd32768) return 16'sh8000;
        return 16'(r);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 128; i++) hist[i] = 16'sd0;
        ptr = 0;
        sbq.delete();
        contig = 1'b0;
    endtask

    // Drive one sample, wait for acceptance, push the expected result.
    task automatic send(input logic signed [15:0] s, input bit has_tbl, input logic signed [15:0] tv);
        int     waited;
        longint at, al;
        sb_t    e;
        in_valid  = 1'b1;
        in_sample = s;
        waited    = 0;
        while (!in_ready_t && waited < 400) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready_t) begin
            chk("accept_timeout", waited, 0);
            return;
        end
        if (contig) chk("accept_spacing", longint'(cyc) - last_acc, 131);
        last_acc = cyc;
        contig   = 1'b1;
        hist[ptr] = s;
        at = 0;
        al = 0;
        for (int k = 0; k < 128; k++) begin
            at += longint'(hist[(ptr - k) & 127]) * 1024;
            al += longint'(hist[(ptr - k) & 127]) * coef_l[k];
        end
        e.e_t     = rsat(at);
        e.e_l     = rsat(al);
        e.due     = longint'(cyc) + 131;
        e.has_tbl = has_tbl;
        e.tbl_v   = tv;
        sbq.push_back(e);
        ptr = (ptr + 1) & 127;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_clear(input string name);
        int n;
        n = 0;
        while (!in_ready_t && n < 300) begin
            n++;
            @(negedge clk);
        end
        chk(name, n, 128);
    endtask

    seg_t segs [5];

    initial begin
        int m;
        sb_t e;
        for (int k = 0; k < 128; k++) begin
            m = ((k + 1) < (128 - k)) ? (k + 1) : (128 - k);
            coef_l[k] = 8 * m;
        end
        segs[0] = '{sample: 16'sd32767,  count: 1,   exp_last: 16'sd1024};
        segs[1] = '{sample: 16'sd0,      count: 127, exp_last: 16'sd1024};
        segs[2] = '{sample: 16'sd0,      count: 2,   exp_last: 16'sd0};
        segs[3] = '{sample: 16'sd32767,  count: 128, exp_last: 16'sd32767};
        segs[4] = '{sample: -16'sd32768, count: 128, exp_last: -16'sd32768};

        rrx_rst   = 1'b1;
        in_valid  = 1'b0;
        in_sample = 16'sd0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_in_ready", in_ready_t, 0);
        chk("rst_busy", busy_t, 1);
        chk("rst_out_valid", out_valid_t, 0);
        chk("rst_out_sample", out_sample_t, 0);
        rrx_rst = 1'b0;
        wait_clear("clear_len");

        fork
            forever begin
                @(negedge clk);
                if (busy_t == in_ready_t || busy_l == in_ready_l) chk("busy_vs_ready", busy_t, !in_ready_t);
                if (out_valid_t || out_valid_l) begin
                    chk("valid_pair", out_valid_l, out_valid_t);
                    if (sbq.size() == 0) begin
                        chk("unexpected_out_valid", out_valid_t, 0);
                    end else begin
                        e = sbq.pop_front();
                        chk("latency", cyc, e.due);
                        chk("test_out", out_sample_t, e.e_t);
                        chk("lp_out", out_sample_l, e.e_l);
                        if (e.has_tbl) chk("table_point", out_sample_t, e.tbl_v);
                    end
                end
            end
        join_none

        // Impulse response and saturation, in_valid held high throughout.
        for (int s = 0; s < 5; s++) begin
            for (int i = 0; i < segs[s].count; i++) begin
                send(segs[s].sample, i == segs[s].count - 1, segs[s].exp_last);
            end
        end

        // Random samples, low-pass coefficients checked across pointer wraps.
        for (int i = 0; i < 24; i++) begin
            send(16'($urandom), 1'b0, 16'sd0);
        end

        in_valid = 1'b0;
        contig   = 1'b0;
        repeat (140) @(negedge clk);
        chk("idle_drain", sbq.size(), 0);

        // Reset 60 cycles into a MAC: result discarded, buffer cleared again.
        send(16'sd12345, 1'b0, 16'sd0);
        repeat (60) @(negedge clk);
        rrx_rst  = 1'b1;
        in_valid = 1'b0;
        model_reset();
        @(negedge clk);
        rrx_rst = 1'b0;
        chk("midrst_out_sample_t", out_sample_t, 0);
        chk("midrst_out_sample_l", out_sample_l, 0);
        chk("midrst_out_valid", out_valid_t, 0);
        wait_clear("midrst_clear_len");
        send(16'sd32767, 1'b1, 16'sd1024);
        for (int i = 0; i < 3; i++) send(16'sd0, 1'b1, 16'sd1024);

        in_valid = 1'b0;
        for (int i = 0; i < 200 && sbq.size() != 0; i++) @(negedge clk);
        chk("final_drain", sbq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
